cla_subtractor_pipe: RTL and testbench

- Pipelined, handshaked WIDTH-bit subtractor: D = A - B - BORROW_IN.
- Inverse companion of the team's carry_lookahead_adder.
- Splits the operands into STAGES segments. Each segment is resolved by an internal carry-lookahead slice, one segment per clock.
- Sits between an operand producer and a result consumer, both using valid/ready.

---
 rtl/cla_subtractor_pipe_if.sv | 26 ++
 rtl/cla_subtractor_pipe.sv | 126 ++++++++++++
 tb/tb_cla_subtractor_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// Producer drives the operand side, consumer takes the result side.
interface cla_subtractor_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BORROW_IN;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] D;
   logic             BORROW_OUT;
   logic             OVERFLOW;

   modport master (
      output in_valid, A, B, BORROW_IN, out_ready,
      input  in_ready, out_valid, D, BORROW_OUT, OVERFLOW
   );

   modport slave (
      input  in_valid, A, B, BORROW_IN, out_ready,
      output in_ready, out_valid, D, BORROW_OUT, OVERFLOW
   );
endinterface

// File: rtl/cla_subtractor_pipe.sv
// Pipelined A - B - BORROW_IN, one carry-lookahead segment per stage.
// Operands ride along so each stage resolves its own segment.
module cla_subtractor_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cla_subtractor_pipe_if.slave bus
);
   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   function automatic logic [SEG:0] cla_seg(
      input logic [SEG-1:0] a,
      input logic [SEG-1:0] b,
      input logic           cin
   );
      logic [SEG-1:0] g;
      logic [SEG-1:0] p;
      logic [SEG:0]   c;
      logic           gg;
      logic           pp;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      // each carry from its own group generate/propagate term
      for (int i = 0; i < SEG; i++) begin
         gg = 1'b0;
         pp = 1'b1;
         for (int j = 0; j <= i; j++) begin
            gg = g[j] | (p[j] & gg);
            pp = pp & p[j];
         end
         c[i+1] = gg | (pp & cin);
      end
      return {c[SEG], p ^ c[SEG-1:0]};
   endfunction

   function automatic logic [WIDTH-1:0] merge(
      input logic [WIDTH-1:0] d,
      input logic [SEG-1:0]   s,
      input int               k
   );
      logic [WIDTH-1:0] r;
      r = d;
      r[k*SEG +: SEG] = s;
      return r;
   endfunction

   logic             advance;
   logic             ovf_q;
   logic             ovf_nx;
   logic             vld  [STAGES];
   logic             cq   [STAGES];
   logic [WIDTH-1:0] aq   [STAGES];
   logic [WIDTH-1:0] bq   [STAGES];
   logic [WIDTH-1:0] dq   [STAGES];
   logic             v_in [STAGES];
   logic             c_in [STAGES];
   logic [WIDTH-1:0] a_in [STAGES];
   logic [WIDTH-1:0] b_in [STAGES];
   logic [WIDTH-1:0] d_in [STAGES];
   logic [WIDTH-1:0] d_nx [STAGES];
   logic             c_nx [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG:0] r;

      if (k == 0) begin : g_head
         assign v_in[k] = bus.in_valid;
         assign a_in[k] = bus.A;
         assign b_in[k] = bus.B;
         assign c_in[k] = ~bus.BORROW_IN;
         assign d_in[k] = '0;
      end else begin : g_body
         assign v_in[k] = vld[k-1];
         assign a_in[k] = aq[k-1];
         assign b_in[k] = bq[k-1];
         assign c_in[k] = cq[k-1];
         assign d_in[k] = dq[k-1];
      end

      assign r       = cla_seg(a_in[k][k*SEG +: SEG],
                               ~b_in[k][k*SEG +: SEG],
                               c_in[k]);
      assign c_nx[k] = r[SEG];
      assign d_nx[k] = merge(d_in[k], r[SEG-1:0], k);
   end

   assign ovf_nx = (a_in[LAST][WIDTH-1] != b_in[LAST][WIDTH-1])
                && (d_nx[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

   assign advance        = !vld[LAST] || bus.out_ready;
   assign bus.in_ready   = advance;
   assign bus.out_valid  = vld[LAST];
   assign bus.D          = dq[LAST];
   assign bus.BORROW_OUT = ~cq[LAST];
   assign bus.OVERFLOW   = ovf_q;

   // carries reset high so the idle BORROW_OUT reads 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld[k] <= 1'b0;
            cq[k]  <= 1'b1;
            aq[k]  <= '0;
            bq[k]  <= '0;
            dq[k]  <= '0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            vld[k] <= v_in[k];
            if (v_in[k]) begin
               aq[k] <= a_in[k];
               bq[k] <= b_in[k];
               dq[k] <= d_nx[k];
               cq[k] <= c_nx[k];
            end
         end
         if (v_in[LAST]) ovf_q <= ovf_nx;
      end
   end
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Bench for cla_subtractor_pipe: directed cases plus a random soak
// scored against an arithmetic reference queue.
module tb_cla_subtractor_pipe;
   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        ovf;
   } res_t;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   nout  = 0;
   res_t exp_q[$];
   res_t e;

   cla_subtractor_pipe_if #(.WIDTH(32)) bus ();

   cla_subtractor_pipe #(.WIDTH(32), .STAGES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic        bin);
      res_t        r;
      longint      sa;
      longint      sb;
      longint      sd;
      longint unsigned ua;
      longint unsigned ub;
      ua    = a;
      ub    = b;
      sa    = $signed(a);
      sb    = $signed(b);
      sd    = sa - sb - longint'(bin);
      r.d   = 32'(ua - ub - 64'(bin));
      r.bo  = (ua < ub + 64'(bin));
      r.ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return r;
   endfunction

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            check("stale_out", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sb_d", bus.D, e.d);
               check("sb_bo", bus.BORROW_OUT, e.bo);
               check("sb_ovf", bus.OVERFLOW, e.ovf);
               nout++;
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.A, bus.B, bus.BORROW_IN));
      end
   end

   task automatic send(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic        bin);
      int n;
      n             = 0;
      bus.in_valid  = 1'b1;
      bus.A         = a;
      bus.B         = b;
      bus.BORROW_IN = bin;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 64'(n < 50), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic one(input string       tag,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic        bin,
                      input logic [31:0] ed,
                      input logic        ebo,
                      input logic        eovf);
      send(a, b, bin);
      check({tag, "_lat0"}, bus.out_valid, 0);
      for (int j = 1; j <= 3; j++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s_lat%0d", tag, j), bus.out_valid, 64'(j == 3));
      end
      check({tag, "_d"}, bus.D, ed);
      check({tag, "_bo"}, bus.BORROW_OUT, ebo);
      check({tag, "_ovf"}, bus.OVERFLOW, eovf);
      @(posedge clk);
      #1;
      check({tag, "_once"}, bus.out_valid, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          i;
      int          nbase;
      int          sent;
      int          cyc;
      int          w;
      logic [31:0] dhold;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.A         = '0;
      bus.B         = '0;
      bus.BORROW_IN = 1'b0;
      dhold         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", bus.out_valid, 0);
      check("rst_d", bus.D, 0);
      check("rst_bo", bus.BORROW_OUT, 0);
      check("rst_ovf", bus.OVERFLOW, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ready", bus.in_ready, 1);

      one("basic", 32'd100, 32'd58, 1'b0, 32'd42, 1'b0, 1'b0);
      one("wrap", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      one("bin", 32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      one("ovf", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      one("xseg", 32'h0001_0000, 32'h0000_00FF, 1'b0,
          32'h0000_FF01, 1'b0, 1'b0);

      nbase = nout;
      i     = 0;
      for (int c = 0; c < 40; c++) begin
         bus.out_ready = !(c >= 6 && c <= 8);
         if (i < 8) begin
            bus.in_valid  = 1'b1;
            bus.A         = 32'h1111 * (i + 1);
            bus.B         = i * 3 + 1;
            bus.BORROW_IN = i[0];
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         if (c >= 6 && c <= 8) begin
            check("stall_ready", bus.in_ready, 0);
            check("stall_valid", bus.out_valid, 1);
            if (c == 6) dhold = bus.D;
            else check("stall_d", bus.D, dhold);
         end
         if (bus.in_valid && bus.in_ready) i++;
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      check("stream_sent", i, 8);
      check("stream_out", nout - nbase, 8);
      check("stream_q", exp_q.size(), 0);

      for (int k = 0; k < 3; k++) begin
         bus.in_valid  = 1'b1;
         bus.A         = 32'd50 + k;
         bus.B         = 32'd8;
         bus.BORROW_IN = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_d", bus.D, 32'd42);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_d", bus.D, 0);
      check("mid_rst_bo", bus.BORROW_OUT, 0);
      check("mid_rst_ovf", bus.OVERFLOW, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", bus.out_valid, 0);
      one("after_rst", 32'd7, 32'd3, 1'b0, 32'd4, 1'b0, 1'b0);

      nbase = nout;
      sent  = 0;
      cyc   = 0;
      while (sent < 10000 && cyc < 60000) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.A         = pick();
         bus.B         = pick();
         bus.BORROW_IN = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) sent++;
         cyc++;
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      w = 0;
      while (exp_q.size() > 0 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("soak_sent", sent, 10000);
      check("soak_drain", exp_q.size(), 0);
      check("soak_out", nout - nbase, 10000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
